// File: rtl/vga_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : vga_pkg                                                |
// | Purpose : 640x480 timing constants, lock states, coordinate type |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package vga_pkg;

    localparam int H_TOTAL  = 800;
    localparam int H_ACTIVE = 640;
    localparam int V_TOTAL  = 525;
    localparam int V_ACTIVE = 480;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        CHECKING = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    function automatic coord_t sat_inc(input coord_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : sync_edge_det                                          |
// | Purpose : input register, previous sample and fall/rise pulses   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module sync_edge_det (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic q,
    output logic fall,
    output logic rise
);

    logic s_d, s_q;
    logic p_d, p_q;

    always_comb begin
        s_d = d;
        p_d = s_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            s_q <= 1'b0;
            p_q <= 1'b0;
        end else begin
            s_q <= s_d;
            p_q <= p_d;
        end
    end

    assign q    = s_q;
    assign fall = p_q & ~s_q;
    assign rise = ~p_q & s_q;

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : vga_sync_decoder                                       |
// | Purpose : recovers x/y, measures line/frame timing, tracks lock  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module vga_sync_decoder #(
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int LOCK_FRAMES = 2,
    parameter int WDOG_CYCLES = 1600
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       hs,
    input  logic       vs,
    input  logic       blank,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic [7:0] err_cnt
);
    import vga_pkg::*;

    localparam coord_t            H_TOT_C   = coord_t'(H_TOTAL);
    localparam coord_t            V_TOT_C   = coord_t'(V_TOTAL);
    localparam int                GC_W      = $clog2(LOCK_FRAMES + 1);
    localparam int                WD_W      = $clog2(WDOG_CYCLES + 1);
    localparam logic [GC_W-1:0]   LOCK_C    = GC_W'(LOCK_FRAMES);
    localparam logic [WD_W-1:0]   WD_LAST_C = WD_W'(WDOG_CYCLES - 1);

    logic hs_fall, vs_fall, act_rise, blank_q;
    logic hs_q_unused, vs_q_unused, hs_rise_unused, vs_rise_unused, blank_fall_unused;

    sync_edge_det u_hs    (.Clk(Clk), .Reset(Reset), .d(hs),    .q(hs_q_unused),
                           .fall(hs_fall),           .rise(hs_rise_unused));
    sync_edge_det u_vs    (.Clk(Clk), .Reset(Reset), .d(vs),    .q(vs_q_unused),
                           .fall(vs_fall),           .rise(vs_rise_unused));
    sync_edge_det u_blank (.Clk(Clk), .Reset(Reset), .d(blank), .q(blank_q),
                           .fall(blank_fall_unused), .rise(act_rise));

    lock_state_t     state_d, state_q;
    logic [GC_W-1:0] good_cnt_d, good_cnt_q;
    logic [WD_W-1:0] wd_d, wd_q;
    coord_t          h_meas_d, h_meas_q, v_meas_d, v_meas_q, v_cnt;
    coord_t          line_len_d, line_len_q, frame_lines_d, frame_lines_q;
    coord_t          x_d, x_q, y_d, y_q;
    logic [7:0]      err_cnt_d, err_cnt_q;
    logic            h_primed_d, h_primed_q, frame_bad_d, frame_bad_q;
    logic            v_arm_d, v_arm_q;
    logic            locked_d, locked_q, pix_valid_d, pix_valid_q;
    logic            frame_start_d, frame_start_q;
    logic            line_bad, frame_good, wdog_trip;

    // Measurement: the hs edge of a coincident hs/vs pair belongs to the ending frame.
    always_comb begin
        h_meas_d   = hs_fall ? '0 : sat_inc(h_meas_q);
        line_len_d = line_len_q;
        h_primed_d = h_primed_q;
        line_bad   = 1'b0;
        wdog_trip  = ~hs_fall & (wd_q >= WD_LAST_C);
        wd_d       = hs_fall ? '0 : ((wd_q >= WD_LAST_C) ? wd_q : wd_q + 1'b1);
        if (hs_fall) begin
            line_len_d = sat_inc(h_meas_q);
            line_bad   = h_primed_q & (sat_inc(h_meas_q) != H_TOT_C);
            h_primed_d = 1'b1;
        end
        if (wdog_trip) begin
            h_primed_d = 1'b0;
        end
        v_cnt         = hs_fall ? sat_inc(v_meas_q) : v_meas_q;
        v_meas_d      = vs_fall ? '0 : v_cnt;
        frame_lines_d = vs_fall ? v_cnt : frame_lines_q;
        frame_bad_d   = vs_fall ? 1'b0 : (frame_bad_q | line_bad);
        frame_good    = ~(frame_bad_q | line_bad) & (v_cnt == V_TOT_C);
    end

    // Lock FSM: next state.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (wdog_trip) begin
            state_d    = UNLOCKED;
            good_cnt_d = '0;
        end else if (vs_fall) begin
            case (state_q)
                UNLOCKED: begin
                    state_d    = CHECKING;
                    good_cnt_d = '0;
                end
                CHECKING: begin
                    if (!frame_good) begin
                        good_cnt_d = '0;
                    end else if (good_cnt_q + 1'b1 == LOCK_C) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!frame_good) begin
                        state_d    = CHECKING;
                        good_cnt_d = '0;
                        err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 1'b1;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    // Lock FSM: outputs.
    always_comb begin
        locked_d      = (state_d == LOCKED);
        pix_valid_d   = locked_d & blank_q;
        frame_start_d = act_rise & v_arm_q & locked_d;
    end

    always_comb begin
        x_d     = act_rise ? '0 : sat_inc(x_q);
        y_d     = act_rise ? (v_arm_q ? '0 : sat_inc(y_q)) : y_q;
        v_arm_d = vs_fall | (v_arm_q & ~act_rise);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q       <= UNLOCKED;
            good_cnt_q    <= '0;
            err_cnt_q     <= '0;
            wd_q          <= '0;
            h_meas_q      <= '0;
            v_meas_q      <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            h_primed_q    <= 1'b0;
            frame_bad_q   <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            v_arm_q       <= 1'b0;
            locked_q      <= 1'b0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            err_cnt_q     <= err_cnt_d;
            wd_q          <= wd_d;
            h_meas_q      <= h_meas_d;
            v_meas_q      <= v_meas_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            h_primed_q    <= h_primed_d;
            frame_bad_q   <= frame_bad_d;
            x_q           <= x_d;
            y_q           <= y_d;
            v_arm_q       <= v_arm_d;
            locked_q      <= locked_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receiving end of the 640x480 VGA timing interface. Samples hs/vs/blank as produced by the team's VGA timing generator, one sample per Clk. Recovers pixel coordinates, measures line and frame timing, and asserts lock once timing is stable. Used as an on-chip monitor and as the coordinate source for capture and overlay logic fed from a raw sync stream.

Parameters:
H_TOTAL, 800, expected Clk cycles between consecutive hs falling edges
V_TOTAL, 525, expected hs falling edges between consecutive vs falling edges
LOCK_FRAMES, 2, consecutive good frames required to assert locked
WDOG_CYCLES, 1600, maximum cycles without an hs falling edge before lock is dropped

Ports:
Clk  in  1  single clock, one pixel sample per cycle
Reset  in  1  reset, synchronous and active-low (asserted when 0)
hs  in  1  horizontal sync, active low
vs  in  1  vertical sync, active low
blank  in  1  display enable, 1 = active pixel
x  out  10  recovered column, aligned with pix_valid
y  out  10  recovered row
pix_valid  out  1  locked & blank_q
frame_start  out  1  one-cycle pulse on the first active pixel of a frame
locked  out  1  timing locked
line_len  out  10  last measured hs period, saturates at 1023
frame_lines  out  10  last measured hs edges per frame, saturates at 1023
err_cnt  out  8  bad frames seen while locked, saturating

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-low.
- While Reset=0 at a Clk edge, every output is 0 and the FSM is UNLOCKED; internal counters, edge registers and good_cnt are cleared.
- Input stage: hs_q/vs_q/blank_q registered once; hs_p/vs_p/blank_p hold the previous samples. All outputs have 1-cycle latency from the inputs.
- Edges: hs_fall = hs_p & ~hs_q; vs_fall = vs_p & ~vs_q; act_rise = ~blank_p & blank_q.
- h_meas: cleared to 0 on hs_fall, otherwise increments, saturating at 1023. On hs_fall, line_len <= min(h_meas+1, 1023).
- A period of 800 therefore reads line_len=800.
- h_primed: set on the first hs_fall after reset or after entering UNLOCKED. A line-length check happens only when h_primed was already set.
- On a checked hs_fall with line_len != H_TOTAL, set frame_bad.
- v_meas: increments on each hs_fall and is cleared on vs_fall. On vs_fall, frame_lines <= v_meas.
- If hs_fall and vs_fall occur in the same cycle, the hs_fall is counted into the ending frame first.
- Frame evaluation on each vs_fall: good = ~frame_bad & (v_meas == V_TOTAL). frame_bad is then cleared.
- FSM UNLOCKED: the first vs_fall moves to CHECKING with good_cnt=0. No evaluation is made, because a partial frame preceded it.
- FSM CHECKING: on each vs_fall, a good frame increments good_cnt; when good_cnt reaches LOCK_FRAMES, go to LOCKED. A bad frame clears good_cnt.
- FSM LOCKED: a bad frame returns to CHECKING, clears good_cnt and increments err_cnt (saturating at 255).
- Watchdog: if no hs_fall occurs for WDOG_CYCLES cycles, go to UNLOCKED from any state and clear h_primed. err_cnt is kept.
- locked = (state == LOCKED), registered.
- x: 0 on act_rise, else x+1, saturating at 1023.
- y: vs_fall sets v_arm. The first act_rise with v_arm set gives y=0, clears v_arm and pulses frame_start (only if locked). Each later act_rise gives y+1, saturating at 1023.
- x and y update regardless of lock; pix_valid qualifies them.
- With nominal input, x runs 0..639 and y 0..479 while pix_valid=1.

Decomposition:
- Package vga_pkg: H_TOTAL/H_ACTIVE/V_TOTAL/V_ACTIVE constants (800/640/525/480), lock_state_t enum {UNLOCKED, CHECKING, LOCKED}, coordinate typedef logic [9:0].
- Sub-module sync_edge_det: per-signal input register, previous-sample register and fall/rise pulses. Instantiated three times.
- Measurement counters and FSM stay in the top module.

Test Plan:
- Drive nominal 800x525 timing from the team's VGA timing generator, LOCK_FRAMES=2 -> locked rises 1 cycle after the 3rd vs_fall. line_len=800, frame_lines=525, err_cnt=0.
- Locked, then capture pix_valid pixels for one frame -> exactly 640*480=307200 pixels. The first has x=0/y=0 together with frame_start; the last has x=639/y=479.
- Locked, then stretch one line to 801 cycles -> at the next vs_fall locked=0 and err_cnt=1. locked returns after 2 further good frames.
- Locked, then hold hs high for 1601 cycles -> locked=0, state UNLOCKED. Relock requires 1 vs_fall plus 2 good frames.
- Frame with 524 lines -> frame_lines=524, frame counted bad, good_cnt=0.
- Assert Reset=0 mid-frame while locked -> next cycle all outputs are 0. After release, locked stays 0 until 3 vs_fall edges have passed.
